// File: rtl/dp_reservation_station_pkg.sv
// Shared definitions for the DP reservation station: CDB channel layout,
// ALU opcodes, ROB tag width and a channel packing helper.
package dp_reservation_station_pkg;

    localparam int TAGW   = 3;
    localparam int XLEN   = 32;
    localparam int CH_W   = 36;
    localparam int NUM_CH = 4;

    // Field positions inside one 36-bit CDB channel
    localparam int VALUE_HI  = 35;
    localparam int VALUE_LO  = 4;
    localparam int VALID_BIT = 3;
    localparam int TAG_HI    = 2;
    localparam int TAG_LO    = 0;

    // Channel offsets on the 144-bit bus; a higher index means higher wakeup priority
    localparam int CH_OFF [NUM_CH] = '{0, 36, 72, 108};   // DP, MEM, MUL, FP

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    // Result of snooping the CDB for one producing tag
    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] value;
    } snoop_t;

    // Build a valid CDB channel word from a result and its ROB tag
    function automatic logic [CH_W-1:0] cdb_pack(input logic [XLEN-1:0] value,
                                                  input logic [TAG_HI:TAG_LO] tag);
        logic [CH_W-1:0] ch;
        ch                     = '0;
        ch[VALUE_HI:VALUE_LO]  = value;
        ch[VALID_BIT]          = 1'b1;
        ch[TAG_HI:TAG_LO]      = tag;
        return ch;
    endfunction

endpackage

// File: rtl/dp_reservation_station_alu.sv
// Single-cycle combinational integer ALU for the DP functional unit.
module dp_alu
    import dp_reservation_station_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    // Opcode decode; shifts use only the low five bits of b
    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dp_reservation_station.sv
// Reservation station for the DP unit: holds issued instructions, snoops
// all four CDB channels for missing operands, dispatches the lowest ready
// entry to the ALU and registers the result onto the DP CDB channel.
module dp_reservation_station #(
    parameter int ENTRIES = 4,
    parameter int TAGW    = dp_reservation_station_pkg::TAGW
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            issue,
    input  logic [2:0]      issue_op,
    input  logic [TAGW-1:0] issue_tag,
    input  logic [31:0]     issue_vj,
    input  logic [31:0]     issue_vk,
    input  logic [TAGW-1:0] issue_qj,
    input  logic [TAGW-1:0] issue_qk,
    input  logic            issue_rj,
    input  logic            issue_rk,
    input  logic [143:0]    CDB,
    output logic            rs_full,
    output logic [35:0]     CDB_DP
);
    import dp_reservation_station_pkg::*;

    localparam int IDXW = $clog2(ENTRIES);

    // Entry array, one vector per field
    logic [ENTRIES-1:0] busy_reg;
    logic [ENTRIES-1:0] rj_reg;
    logic [ENTRIES-1:0] rk_reg;
    logic [2:0]         op_reg  [ENTRIES];
    logic [TAGW-1:0]    tag_reg [ENTRIES];
    logic [XLEN-1:0]    vj_reg  [ENTRIES];
    logic [XLEN-1:0]    vk_reg  [ENTRIES];
    logic [TAGW-1:0]    qj_reg  [ENTRIES];
    logic [TAGW-1:0]    qk_reg  [ENTRIES];

    logic [ENTRIES-1:0] ready_vec;
    logic [IDXW-1:0]    free_idx;
    logic [IDXW-1:0]    sel_idx;
    logic               alloc;
    logic               dispatch;
    logic [XLEN-1:0]    alu_result;
    snoop_t             wake_j [ENTRIES];
    snoop_t             wake_k [ENTRIES];
    snoop_t             byp_j;
    snoop_t             byp_k;

    // Scan channels in ascending order so the highest matching channel wins
    function automatic snoop_t snoop(input logic [TAGW-1:0] q, input logic [NUM_CH*CH_W-1:0] bus);
        snoop_t          s;
        logic [CH_W-1:0] ch;
        s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch = bus[CH_OFF[c] +: CH_W];
            if (ch[VALID_BIT] && (ch[TAG_LO +: TAGW] == q)) begin
                s.hit   = 1'b1;
                s.value = ch[VALUE_HI:VALUE_LO];
            end
        end
        return s;
    endfunction

    // Per-entry wakeup comparators against every CDB channel
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wake
        assign wake_j[gi] = snoop(qj_reg[gi], CDB);
        assign wake_k[gi] = snoop(qk_reg[gi], CDB);
    end

    // Same-cycle bypass for operands arriving unready at issue
    assign byp_j = snoop(issue_qj, CDB);
    assign byp_k = snoop(issue_qk, CDB);

    // Fullness comes from registered busy bits only, so a same-cycle dispatch cannot admit an issue
    assign rs_full   = &busy_reg;
    assign ready_vec = busy_reg & rj_reg & rk_reg;
    assign alloc     = issue & ~rs_full;
    assign dispatch  = |ready_vec;

    // Fixed-priority encoders: lowest free entry for allocation, lowest ready entry for dispatch
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_reg[i]) free_idx = IDXW'(i);
            if (ready_vec[i]) sel_idx  = IDXW'(i);
        end
    end

    dp_alu u_alu (
        .op     (op_reg[sel_idx]),
        .a      (vj_reg[sel_idx]),
        .b      (vk_reg[sel_idx]),
        .result (alu_result)
    );

    // Busy bits: set on allocation, cleared on dispatch, discarded on reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc && (free_idx == IDXW'(i))) begin
                    busy_reg[i] <= 1'b1;
                end else if (dispatch && (sel_idx == IDXW'(i))) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Entry payload: written on allocation, operands captured on wakeup; only meaningful while busy
    always_ff @(posedge CLK) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (alloc && (free_idx == IDXW'(i))) begin
                op_reg[i]  <= issue_op;
                tag_reg[i] <= issue_tag;
                qj_reg[i]  <= issue_qj;
                qk_reg[i]  <= issue_qk;
                vj_reg[i]  <= issue_rj ? issue_vj : byp_j.value;
                vk_reg[i]  <= issue_rk ? issue_vk : byp_k.value;
                rj_reg[i]  <= issue_rj | byp_j.hit;
                rk_reg[i]  <= issue_rk | byp_k.hit;
            end else if (busy_reg[i]) begin
                if (!rj_reg[i] && wake_j[i].hit) begin
                    vj_reg[i] <= wake_j[i].value;
                    rj_reg[i] <= 1'b1;
                end
                if (!rk_reg[i] && wake_k[i].hit) begin
                    vk_reg[i] <= wake_k[i].value;
                    rk_reg[i] <= 1'b1;
                end
            end
        end
    end

    // DP channel output: one-cycle pulse per dispatch, zero otherwise
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            CDB_DP <= '0;
        end else if (dispatch) begin
            CDB_DP <= cdb_pack(alu_result, tag_reg[sel_idx]);
        end else begin
            CDB_DP <= '0;
        end
    end

endmodule

// File: tb/tb_dp_reservation_station.sv
// Self-checking bench for dp_reservation_station: directed scenarios plus a
// randomized run, all compared against a behavioural station model.
module tb_dp_reservation_station;

    localparam int N = 4;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          issue;
    logic [2:0]    issue_op;
    logic [2:0]    issue_tag;
    logic [31:0]   issue_vj, issue_vk;
    logic [2:0]    issue_qj, issue_qk;
    logic          issue_rj, issue_rk;
    logic [35:0]   ch_mem, ch_mul, ch_fp;
    logic [143:0]  CDB;
    logic          rs_full;
    logic [35:0]   CDB_DP;

    int errors = 0;
    int checks = 0;

    // DP channel is looped back from the station's own output
    assign CDB = {ch_fp, ch_mul, ch_mem, CDB_DP};

    always #5 CLK = ~CLK;

    dp_reservation_station #(.ENTRIES(N), .TAGW(3)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .issue     (issue),
        .issue_op  (issue_op),
        .issue_tag (issue_tag),
        .issue_vj  (issue_vj),
        .issue_vk  (issue_vk),
        .issue_qj  (issue_qj),
        .issue_qk  (issue_qk),
        .issue_rj  (issue_rj),
        .issue_rk  (issue_rk),
        .CDB       (CDB),
        .rs_full   (rs_full),
        .CDB_DP    (CDB_DP)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        busy;
        bit [2:0]  op;
        bit [2:0]  tag;
        bit [31:0] vj, vk;
        bit [2:0]  qj, qk;
        bit        rj, rk;
    } ent_t;

    ent_t      m [N];
    bit [35:0] m_dp = '0;

    function automatic bit [31:0] alu_ref(bit [2:0] op, bit [31:0] a, bit [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m[i].busy = 1'b0;
        m_dp = '0;
    endtask

    // Advance one clock edge: update the model from pre-edge inputs, then settle past the edge
    task automatic step();
        ent_t      nxt [N];
        bit [35:0] chans [4];
        bit [35:0] new_dp;
        int        sel, fr;
        @(posedge CLK);
        if (Reset) begin
            model_clear();
        end else begin
            chans[0] = m_dp; chans[1] = ch_mem; chans[2] = ch_mul; chans[3] = ch_fp;
            nxt = m; sel = -1; fr = -1; new_dp = '0;
            for (int i = 0; i < N; i++) if (sel < 0 && m[i].busy && m[i].rj && m[i].rk) sel = i;
            for (int i = 0; i < N; i++) if (fr < 0 && !m[i].busy) fr = i;
            for (int i = 0; i < N; i++) begin
                if (m[i].busy) begin
                    for (int c = 0; c < 4; c++) begin
                        if (!m[i].rj && chans[c][3] && chans[c][2:0] == m[i].qj) begin
                            nxt[i].vj = chans[c][35:4]; nxt[i].rj = 1'b1;
                        end
                        if (!m[i].rk && chans[c][3] && chans[c][2:0] == m[i].qk) begin
                            nxt[i].vk = chans[c][35:4]; nxt[i].rk = 1'b1;
                        end
                    end
                end
            end
            if (sel >= 0) begin
                nxt[sel].busy = 1'b0;
                new_dp = {alu_ref(m[sel].op, m[sel].vj, m[sel].vk), 1'b1, m[sel].tag};
            end
            if (issue && fr >= 0) begin
                nxt[fr].busy = 1'b1;     nxt[fr].op = issue_op; nxt[fr].tag = issue_tag;
                nxt[fr].vj = issue_vj;   nxt[fr].vk = issue_vk;
                nxt[fr].qj = issue_qj;   nxt[fr].qk = issue_qk;
                nxt[fr].rj = issue_rj;   nxt[fr].rk = issue_rk;
                for (int c = 0; c < 4; c++) begin
                    if (!issue_rj && chans[c][3] && chans[c][2:0] == issue_qj) begin
                        nxt[fr].vj = chans[c][35:4]; nxt[fr].rj = 1'b1;
                    end
                    if (!issue_rk && chans[c][3] && chans[c][2:0] == issue_qk) begin
                        nxt[fr].vk = chans[c][35:4]; nxt[fr].rk = 1'b1;
                    end
                end
            end
            m = nxt;
            m_dp = new_dp;
        end
        #1;
        if (m_dp[3]) $display("dispatch tag=%0d value=0x%08h (dut cdb_dp=0x%09h)", m_dp[2:0], m_dp[35:4], CDB_DP);
    endtask

    task automatic clear_inputs();
        issue = 1'b0; issue_op = '0; issue_tag = '0;
        issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
        issue_rj = 1'b0; issue_rk = 1'b0;
        ch_mem = '0; ch_mul = '0; ch_fp = '0;
    endtask

    task automatic put_issue(input logic [2:0] op, input logic [2:0] tag,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input logic [2:0] qj, input logic [2:0] qk,
                             input logic rj, input logic rk);
        issue = 1'b1; issue_op = op; issue_tag = tag;
        issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
        issue_rj = rj; issue_rk = rk;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        clear_inputs();
        step();
        step();
        Reset = 1'b0;
        #1;
        checks++;
        if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_rs_full got=%b exp=0", rs_full); end
        checks++;
        if (CDB_DP !== 36'h0) begin errors++; $display("FAIL reset_cdb_dp got=%h exp=0", CDB_DP); end
    endtask

    task automatic test_add();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) put_issue(3'd0, 3'd2, 32'd5, 32'd7, 3'd0, 3'd0, 1'b1, 1'b1);
            else issue = 1'b0;
            step();
            checks += 3;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL add_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== 1'b0) begin errors++; $display("FAIL add_full c=%0d got=%b exp=0", c, rs_full); end
            if (c == 1 && CDB_DP !== {32'd12, 1'b1, 3'd2}) begin errors++; $display("FAIL add_result got=%h exp=%h", CDB_DP, {32'd12, 1'b1, 3'd2}); end
            else if (c != 1 && CDB_DP !== 36'h0) begin errors++; $display("FAIL add_idle c=%0d got=%h exp=0", c, CDB_DP); end
        end
    endtask

    task automatic test_wakeup();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            if (c == 0) put_issue(3'd1, 3'd1, 32'd0, 32'd3, 3'd4, 3'd0, 1'b0, 1'b1);
            if (c == 3) ch_mul = {32'd10, 1'b1, 3'd4};
            step();
            checks += 2;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL wake_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== model_full()) begin errors++; $display("FAIL wake_full c=%0d got=%b exp=%b", c, rs_full, model_full()); end
            if (c == 4) begin
                checks++;
                if (CDB_DP !== {32'd7, 1'b1, 3'd1}) begin errors++; $display("FAIL wake_result got=%h exp=%h", CDB_DP, {32'd7, 1'b1, 3'd1}); end
            end
        end
    endtask

    task automatic test_bypass();
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            if (c == 0) begin
                put_issue(3'd0, 3'd3, 32'd1, 32'd0, 3'd0, 3'd6, 1'b1, 1'b0);
                ch_mem = {32'h20, 1'b1, 3'd6};
            end
            step();
            checks += 2;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL byp_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== model_full()) begin errors++; $display("FAIL byp_full c=%0d got=%b exp=%b", c, rs_full, model_full()); end
            if (c == 1) begin
                checks++;
                if (CDB_DP !== {32'h21, 1'b1, 3'd3}) begin errors++; $display("FAIL byp_result got=%h exp=%h", CDB_DP, {32'h21, 1'b1, 3'd3}); end
            end
        end
    endtask

    task automatic test_fill();
        logic [35:0] e;
        for (int c = 0; c < 11; c++) begin
            clear_inputs();
            if (c < 4) put_issue(3'd0, 3'(c), 32'd0, 32'(c), 3'd5, 3'd0, 1'b0, 1'b1);
            if (c == 4) put_issue(3'd0, 3'd7, 32'd1, 32'd1, 3'd0, 3'd0, 1'b1, 1'b1);
            if (c == 5) ch_fp = {32'd100, 1'b1, 3'd5};
            step();
            checks += 2;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL fill_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== model_full()) begin errors++; $display("FAIL fill_full c=%0d got=%b exp=%b", c, rs_full, model_full()); end
            if (c == 3 || c == 4 || c == 5) begin
                checks++;
                if (rs_full !== 1'b1) begin errors++; $display("FAIL fill_full_const c=%0d got=%b exp=1", c, rs_full); end
            end
            if (c >= 6) begin
                e = (c <= 9) ? {32'(100 + c - 6), 1'b1, 3'(c - 6)} : 36'h0;
                checks++;
                if (CDB_DP !== e) begin errors++; $display("FAIL fill_order c=%0d got=%h exp=%h", c, CDB_DP, e); end
            end
        end
    endtask

    task automatic test_edge_ops();
        logic [35:0] e;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: put_issue(3'd7, 3'd4, 32'hFFFF_FFFF, 32'd1,  3'd0, 3'd0, 1'b1, 1'b1);
                1: put_issue(3'd6, 3'd5, 32'h8000_0000, 32'd31, 3'd0, 3'd0, 1'b1, 1'b1);
                2: put_issue(3'd0, 3'd6, 32'hFFFF_FFFF, 32'd1,  3'd0, 3'd0, 1'b1, 1'b1);
                default: ;
            endcase
            step();
            checks += 2;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL edge_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== model_full()) begin errors++; $display("FAIL edge_full c=%0d got=%b exp=%b", c, rs_full, model_full()); end
            case (c)
                1: e = {32'd1, 1'b1, 3'd4};
                2: e = {32'd1, 1'b1, 3'd5};
                3: e = {32'd0, 1'b1, 3'd6};
                default: e = 36'h0;
            endcase
            checks++;
            if (CDB_DP !== e) begin errors++; $display("FAIL edge_result c=%0d got=%h exp=%h", c, CDB_DP, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) put_issue(3'd0, 3'd2, 32'd3, 32'd4,  3'd0, 3'd0, 1'b1, 1'b1);
            if (c == 1) put_issue(3'd0, 3'd3, 32'd0, 32'd10, 3'd2, 3'd0, 1'b0, 1'b1);
            step();
            checks += 2;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL b2b_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== model_full()) begin errors++; $display("FAIL b2b_full c=%0d got=%b exp=%b", c, rs_full, model_full()); end
            e = (c == 1) ? {32'd7, 1'b1, 3'd2} : (c == 3) ? {32'd17, 1'b1, 3'd3} : 36'h0;
            checks++;
            if (CDB_DP !== e) begin errors++; $display("FAIL b2b_result c=%0d got=%h exp=%h", c, CDB_DP, e); end
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c < 3)  put_issue(3'd0, 3'(c + 2), 32'd0, 32'd1, 3'd7, 3'd0, 1'b0, 1'b1);
            if (c == 3) put_issue(3'd0, 3'd1, 32'd40, 32'd2, 3'd0, 3'd0, 1'b1, 1'b1);
            step();
            checks++;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL mid_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
        end
        checks++;
        if (CDB_DP !== {32'd42, 1'b1, 3'd1}) begin errors++; $display("FAIL mid_pre got=%h exp=%h", CDB_DP, {32'd42, 1'b1, 3'd1}); end
        Reset = 1'b1;
        model_clear();
        #1;
        checks += 2;
        if (CDB_DP !== 36'h0) begin errors++; $display("FAIL mid_async_cdb got=%h exp=0", CDB_DP); end
        if (rs_full !== 1'b0) begin errors++; $display("FAIL mid_async_full got=%b exp=0", rs_full); end
        step();
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) ch_mul = {32'd9, 1'b1, 3'd7};
            step();
            checks += 2;
            if (CDB_DP !== 36'h0) begin errors++; $display("FAIL mid_after c=%0d got=%h exp=0", c, CDB_DP); end
            if (rs_full !== 1'b0) begin errors++; $display("FAIL mid_after_full c=%0d got=%b exp=0", c, rs_full); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            if ($urandom_range(0, 1) == 1)
                put_issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) ch_mem = {$urandom, 1'b1, 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 2) == 0) ch_mul = {$urandom, 1'b1, 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 2) == 0) ch_fp  = {$urandom, 1'b1, 3'($urandom_range(0, 7))};
            step();
            checks += 2;
            if (CDB_DP !== m_dp) begin errors++; $display("FAIL rand_cdb c=%0d got=%h exp=%h", c, CDB_DP, m_dp); end
            if (rs_full !== model_full()) begin errors++; $display("FAIL rand_full c=%0d got=%b exp=%b", c, rs_full, model_full()); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wakeup();
        test_bypass();
        test_fill();
        test_edge_ops();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
